// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding selects, load-use bubbles, branch flushes and
// memory-stall freezes for a 5-stage RV32I pipeline. It also keeps saturating
// stall counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal flow; every condition is evaluated
// LU_BUBBLE | a bubble was just inserted, so load-use is ignored this cycle
// MEM_WAIT  | pipeline frozen on a cache miss; evaluated as RUN once released
module fwd_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_is_load,
  input  logic             mem_is_store,
  input  logic [4:0]       mem_rs2,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic [1:0]       rs1mux_sel,
  output logic [1:0]       rs2mux_sel,
  output logic             dcachemux_sel,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lu_cnt_q, stall_cnt_q;
  logic             lu_inc, stall_inc;
  logic             mem_busy, lu_hazard;
  logic [6:0]       strb;

  // Operand forwarding: a non-load in MEM wins over WB, and x0 is never forwarded.
  always_comb begin
    rs1mux_sel    = 2'b00;
    rs2mux_sel    = 2'b00;
    dcachemux_sel = 1'b0;
    if (mem_regwrite && !mem_is_load && (mem_rd == ex_rs1) && (ex_rs1 != 5'd0))
      rs1mux_sel = 2'b01;
    else if (wb_regwrite && (wb_rd == ex_rs1) && (ex_rs1 != 5'd0))
      rs1mux_sel = 2'b10;
    if (mem_regwrite && !mem_is_load && (mem_rd == ex_rs2) && (ex_rs2 != 5'd0))
      rs2mux_sel = 2'b01;
    else if (wb_regwrite && (wb_rd == ex_rs2) && (ex_rs2 != 5'd0))
      rs2mux_sel = 2'b10;
    if (mem_is_store && wb_regwrite && (wb_rd == mem_rs2) && (mem_rs2 != 5'd0))
      dcachemux_sel = 1'b1;
    if (!rst) begin
      rs1mux_sel    = 2'b00;
      rs2mux_sel    = 2'b00;
      dcachemux_sel = 1'b0;
    end
  end

  // Stall and hazard conditions.
  always_comb begin
    mem_busy  = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
    lu_hazard = ex_is_load & ex_regwrite & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Next state and stage strobes. Priority: mem_busy > branch > load-use.
  // MEM_WAIT falls through to the RUN rules as soon as memory releases.
  // strb = {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  always_comb begin
    state_d   = RUN;
    strb      = 7'b11111_00;
    lu_inc    = 1'b0;
    stall_inc = 1'b0;
    if (mem_busy) begin
      state_d   = MEM_WAIT;
      strb      = 7'b00000_00;
      stall_inc = 1'b1;
    end else if (ex_br_taken) begin
      strb = 7'b11111_11;
    end else if (lu_hazard && (state_q != LU_BUBBLE)) begin
      state_d = LU_BUBBLE;
      strb    = 7'b00111_01;
      lu_inc  = 1'b1;
    end
    if (!rst) strb = 7'b00000_00;
  end

  assign {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush} = strb;
  assign load_use_cnt  = lu_cnt_q;
  assign mem_stall_cnt = stall_cnt_q;

  // State register and saturating counters; reset wins even mid-stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (lu_inc && (lu_cnt_q != CNT_MAX))
        lu_cnt_q <= lu_cnt_q + CNT_ONE;
      if (stall_inc && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

endmodule
